i2c_slave_reg: RTL
==================

Name: i2c_slave_reg

Overview:
- I2C target (responder) that bridges bus transactions onto a byte-wide register port (RAM or CSR file).
- It is the bench/loopback counterpart of the team's I2C master: it accepts device-address, data-address, then write or read data bytes, with address auto-increment.
- It supports repeated START, so random reads work as write-address followed by Sr plus a read.
- No clock stretching; SCL is input only.

Parameters:
- CLK_FREQ_MHZ, 100, system clock frequency. Informational; it sets the minimum clock needed to reach 400 kHz SCL with FILTER_LEN.
- DEVICE_ADDR, 7'h50, 7-bit address this target responds to.
- DATA_ADDR_BYTES, 2, data-address length in bytes. Legal values are 1 or 2.
- FILTER_LEN, 3, number of consecutive equal synchronized samples required before an SCL/SDA level change is accepted. Range 1..7.

Ports:
- clk  input  1  module clock
- rstn  input  1  asynchronous active-low reset
- sda_i  input  1  SDA pad input
- sda_o  output  1  SDA output value; constant 0 (open-drain)
- sda_oen  output  1  1 = drive sda_o onto the pad (pull low); 0 = release
- scl_i  input  1  SCL pad input
- reg_wr_en  output  1  one-cycle write strobe
- reg_waddr  output  16  write address; upper byte is 0 when DATA_ADDR_BYTES=1
- reg_wdata  output  8  write data
- reg_rd_en  output  1  one-cycle read request
- reg_raddr  output  16  read address
- reg_rdata  input  8  read data, valid exactly 1 clk after reg_rd_en
- busy  output  1  high from an addressed START/Sr until STOP or NACK release
- addr_nack  output  1  one-cycle pulse when a START is followed by a non-matching device address

Behaviour:
- Reset (rstn low, async): state=IDLE, sda_oen=0, reg_wr_en=0, reg_rd_en=0, busy=0, addr_nack=0, all address/data registers 0, filters preloaded to 1.
- Input conditioning:
  - 2-flop synchronizer on scl_i and sda_i, then the FILTER_LEN debounce.
  - scl_rise/scl_fall/sda_rise/sda_fall are single-cycle pulses derived from the filtered levels.
- Bus conditions:
  - START/Sr = sda_fall while SCL high.
  - STOP = sda_rise while SCL high.
  - Both are detected from any state and take priority over bit processing.
- Bit timing: SDA is sampled on scl_rise; sda_oen is updated only on scl_fall.
- Bit counter counts 0..7, MSB first. It resets on START/Sr and after each ACK slot.
- States: IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- IDLE: START -> DEV. All other events are ignored.
- DEV: shift 8 bits. On the scl_fall after bit 7:
  - Address match: drive ACK (sda_oen=1) and go to DEV_ACK. busy=1 from this point.
  - No match: pulse addr_nack, go to IGNORE, leave SDA released.
- DEV_ACK (on the scl_fall ending the ACK slot):
  - Write bit (R/W=0): release SDA. Go to AHI if DATA_ADDR_BYTES=2, otherwise to ALO.
  - Read bit (R/W=1): go to RDATA.
  - For a read, reg_rd_en pulses with reg_raddr = current pointer on the scl_rise of the ACK slot.
  - The byte is latched from reg_rdata 1 clk later.
  - Bit 7 is driven on the scl_fall ending the ACK slot.
- AHI/ALO: shift address byte. Drive ACK after bit 7.
  - After ALO_ACK, pointer = {hi,lo}, or {8'h00,lo} when DATA_ADDR_BYTES=1. Then go to WDATA.
- WDATA: shift byte; on the scl_fall after bit 7:
  - reg_wr_en=1 for 1 clk, with reg_waddr=pointer and reg_wdata=byte.
  - Drive ACK, go to WDATA_ACK.
  - Pointer increments after the strobe.
  - Every data byte is ACKed.
- WDATA_ACK: release SDA, go to WDATA.
- RDATA: sda_oen = ~bit, so a 0 bit pulls low and a 1 bit releases. After the 8th bit's scl_fall, release SDA and go to RACK.
- RACK: sample master ACK on scl_rise.
  - ACK (0): pointer+1, reg_rd_en pulse for the new pointer, then back to RDATA.
  - NACK (1): go to IGNORE; busy drops.
- IGNORE: SDA released until START/Sr (-> DEV) or STOP (-> IDLE).
- Pointer arithmetic: wraps at 16'hFFFF->0 for DATA_ADDR_BYTES=2, and at 8'hFF->0 (upper byte 0) for 1.
- Sr in any state:
  - Release SDA, reset the bit counter, go to DEV.
  - The pointer is retained, which enables random read.
- STOP in any state:
  - Release SDA, go to IDLE, busy=0.
  - A partially received byte is discarded and no reg_wr_en is issued for it.
- Addressed-read pointer: the pointer persists across transactions, so a read without a preceding address phase continues from the last pointer.
- Reset mid-transfer: SDA is released immediately (async), and the block waits in IDLE for the next START.

Test Plan:
- Write 0xA0 0x12 0x34 0x5A 0xC3 + STOP -> ACK on all 5 bytes; reg_wr_en twice (0x1234<=0x5A, 0x1235<=0xC3); busy low after STOP.
- Random read: write 0xA0 0x00 0x10, then Sr 0xA1, master ACKs byte 1 and NACKs byte 2, model returns addr+0x40 -> bytes read 0x50, 0x51; reg_rd_en for 0x0010 and 0x0011 only; SDA released after NACK.
- Address 0xA2 (dev 0x51) -> addr_nack pulse, SDA never driven, no reg strobes, later START with 0xA0 still accepted.
- Pointer wrap: write at 0xFFFF with 2 data bytes -> writes to 0xFFFF then 0x0000. With DATA_ADDR_BYTES=1, 0xFF then 0x00 and upper byte 0.
- STOP after 4 bits of a data byte -> no reg_wr_en, state IDLE; then rstn pulsed during a read byte whose current bit is 0 (SDA driven) -> sda_oen=0 within the reset, next transaction normal.
- Glitch: a 1-clk SCL low spike with FILTER_LEN=3 -> no bit shifted, no state change.

Source files
------------

// File: rtl/i2c_slave_reg.sv
// I2C target that maps bus writes/reads onto a byte-wide register port.
// Filtered SCL/SDA, START/Sr/STOP detection, auto-incrementing pointer, no clock stretching.
module i2c_slave_reg #(
   parameter int unsigned CLK_FREQ_MHZ    = 100,
   parameter logic [6:0]  DEVICE_ADDR     = 7'h50,
   parameter int unsigned DATA_ADDR_BYTES = 2,
   parameter int unsigned FILTER_LEN      = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        sda_i,
   output logic        sda_o,
   output logic        sda_oen,
   input  logic        scl_i,
   output logic        reg_wr_en,
   output logic [15:0] reg_waddr,
   output logic [7:0]  reg_wdata,
   output logic        reg_rd_en,
   output logic [15:0] reg_raddr,
   input  logic [7:0]  reg_rdata,
   output logic        busy,
   output logic        addr_nack
);

   if (DATA_ADDR_BYTES != 1 && DATA_ADDR_BYTES != 2) begin : g_bad_addr_bytes
      $error("i2c_slave_reg: DATA_ADDR_BYTES must be 1 or 2");
   end
   if (FILTER_LEN < 1 || FILTER_LEN > 7) begin : g_bad_filter_len
      $error("i2c_slave_reg: FILTER_LEN must be 1..7");
   end
   // SCL high time at 400 kHz is 0.6 us; sync + filter + edge detect must fit well inside it.
   if (CLK_FREQ_MHZ * 6 < (FILTER_LEN + 3) * 10) begin : g_slow_clk
      $warning("i2c_slave_reg: CLK_FREQ_MHZ too low for 400 kHz SCL with this FILTER_LEN");
   end

   localparam bit ONE_BYTE = (DATA_ADDR_BYTES == 1);

   typedef enum logic [3:0] {
      IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK,
      WDATA, WDATA_ACK, RDATA, RACK, IGNORE
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      sync1_q, sync2_q, filt_q, filt_d, prev_q;   // [0]=SCL, [1]=SDA
   logic [1:0][2:0] fcnt_q, fcnt_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic            full_q, full_d;
   logic [7:0]      shift_q, shift_d, tx_q, tx_d, ahi_q, ahi_d;
   logic [15:0]     ptr_q, ptr_d;
   logic            oen_q, oen_d, busy_q, busy_d, nack_q, nack_d;
   logic            wr_en_q, wr_en_d, rd_en_q, rd_en_d, rd_pend_q;
   logic [15:0]     waddr_q, waddr_d, raddr_q, raddr_d;
   logic [7:0]      wdata_q, wdata_d;

   logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
   logic sda_f, dev_match, rw_bit, shifting;

   function automatic logic [15:0] ptr_inc(input logic [15:0] p);
      if (ONE_BYTE) return {8'h00, p[7:0] + 8'd1};
      return p + 16'd1;
   endfunction

   always_comb begin
      filt_d = filt_q;
      for (int unsigned i = 0; i < 2; i++) begin
         fcnt_d[i] = '0;
         if (sync2_q[i] != filt_q[i]) begin
            if (32'(fcnt_q[i]) + 32'd1 >= FILTER_LEN) filt_d[i] = sync2_q[i];
            else                                      fcnt_d[i] = fcnt_q[i] + 3'd1;
         end
      end
   end

   assign scl_rise  = filt_q[0] & ~prev_q[0];
   assign scl_fall  = ~filt_q[0] & prev_q[0];
   assign sda_rise  = filt_q[1] & ~prev_q[1];
   assign sda_fall  = ~filt_q[1] & prev_q[1];
   assign start_det = sda_fall & filt_q[0];
   assign stop_det  = sda_rise & filt_q[0];
   assign sda_f     = filt_q[1];
   assign dev_match = (shift_q[7:1] == DEVICE_ADDR);
   assign rw_bit    = shift_q[0];   // address byte stays in shift_q through DEV_ACK
   assign shifting  = (state_q == DEV) || (state_q == AHI) || (state_q == ALO) || (state_q == WDATA);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         sync1_q   <= '1;
         sync2_q   <= '1;
         filt_q    <= '1;
         prev_q    <= '1;
         fcnt_q    <= '0;
         bitcnt_q  <= '0;
         full_q    <= 1'b0;
         shift_q   <= '0;
         tx_q      <= '0;
         ahi_q     <= '0;
         ptr_q     <= '0;
         oen_q     <= 1'b0;
         busy_q    <= 1'b0;
         nack_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         rd_pend_q <= 1'b0;
         waddr_q   <= '0;
         raddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= {sda_i, scl_i};
         sync2_q   <= sync1_q;
         filt_q    <= filt_d;
         prev_q    <= filt_q;
         fcnt_q    <= fcnt_d;
         bitcnt_q  <= bitcnt_d;
         full_q    <= full_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         ahi_q     <= ahi_d;
         ptr_q     <= ptr_d;
         oen_q     <= oen_d;
         busy_q    <= busy_d;
         nack_q    <= nack_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         rd_pend_q <= rd_en_q;
         waddr_q   <= waddr_d;
         raddr_q   <= raddr_d;
         wdata_q   <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (stop_det)       state_d = IDLE;
      else if (start_det) state_d = DEV;
      else begin
         case (state_q)
            DEV:       if (scl_fall && full_q) state_d = dev_match ? DEV_ACK : IGNORE;
            DEV_ACK:   if (scl_fall) state_d = rw_bit ? RDATA : (ONE_BYTE ? ALO : AHI);
            AHI:       if (scl_fall && full_q) state_d = AHI_ACK;
            AHI_ACK:   if (scl_fall) state_d = ALO;
            ALO:       if (scl_fall && full_q) state_d = ALO_ACK;
            ALO_ACK:   if (scl_fall) state_d = WDATA;
            WDATA:     if (scl_fall && full_q) state_d = WDATA_ACK;
            WDATA_ACK: if (scl_fall) state_d = WDATA;
            RDATA:     if (scl_fall && bitcnt_q == 3'd7) state_d = RACK;
            RACK: begin
               if (scl_rise && sda_f) state_d = IGNORE;
               else if (scl_fall)     state_d = RDATA;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bitcnt_d = bitcnt_q;
      full_d   = full_q;
      shift_d  = shift_q;
      tx_d     = rd_pend_q ? reg_rdata : tx_q;
      ahi_d    = ahi_q;
      ptr_d    = ptr_q;
      oen_d    = oen_q;
      busy_d   = busy_q;
      nack_d   = 1'b0;
      wr_en_d  = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      rd_en_d  = 1'b0;
      raddr_d  = raddr_q;
      if (stop_det || start_det) begin
         oen_d    = 1'b0;
         bitcnt_d = '0;
         full_d   = 1'b0;
         if (stop_det) busy_d = 1'b0;
      end else begin
         if (scl_rise && shifting) begin
            shift_d  = {shift_q[6:0], sda_f};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) full_d = 1'b1;
         end
         case (state_q)
            DEV: if (scl_fall && full_q) begin
               full_d = 1'b0;
               if (dev_match) begin
                  oen_d  = 1'b1;
                  busy_d = 1'b1;
               end else begin
                  nack_d = 1'b1;
                  busy_d = 1'b0;
               end
            end
            DEV_ACK: begin
               if (scl_rise && rw_bit) begin
                  rd_en_d = 1'b1;
                  raddr_d = ptr_q;
               end
               if (scl_fall) begin
                  bitcnt_d = '0;
                  oen_d    = rw_bit ? ~tx_q[7] : 1'b0;
                  if (rw_bit) tx_d = {tx_q[6:0], 1'b0};
               end
            end
            AHI, ALO, WDATA: if (scl_fall && full_q) begin
               full_d = 1'b0;
               oen_d  = 1'b1;
               if (state_q == AHI) ahi_d = shift_q;
               if (state_q == WDATA) begin
                  wr_en_d = 1'b1;
                  waddr_d = ptr_q;
                  wdata_d = shift_q;
                  ptr_d   = ptr_inc(ptr_q);
               end
            end
            AHI_ACK, WDATA_ACK: if (scl_fall) begin
               oen_d    = 1'b0;
               bitcnt_d = '0;
            end
            ALO_ACK: if (scl_fall) begin
               oen_d    = 1'b0;
               bitcnt_d = '0;
               ptr_d    = ONE_BYTE ? {8'h00, shift_q} : {ahi_q, shift_q};
            end
            RDATA: if (scl_fall) begin
               if (bitcnt_q == 3'd7) begin
                  oen_d    = 1'b0;
                  bitcnt_d = '0;
               end else begin
                  oen_d    = ~tx_q[7];
                  tx_d     = {tx_q[6:0], 1'b0};
                  bitcnt_d = bitcnt_q + 3'd1;
               end
            end
            RACK: begin
               if (scl_rise) begin
                  if (sda_f) busy_d = 1'b0;
                  else begin
                     ptr_d   = ptr_inc(ptr_q);
                     rd_en_d = 1'b1;
                     raddr_d = ptr_inc(ptr_q);
                  end
               end
               if (scl_fall) begin
                  oen_d    = ~tx_q[7];
                  tx_d     = {tx_q[6:0], 1'b0};
                  bitcnt_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sda_o     = 1'b0;
      sda_oen   = oen_q;
      reg_wr_en = wr_en_q;
      reg_waddr = waddr_q;
      reg_wdata = wdata_q;
      reg_rd_en = rd_en_q;
      reg_raddr = raddr_q;
      busy      = busy_q;
      addr_nack = nack_q;
   end

endmodule
